// File: rtl/m68k_debug_uart_tx.sv
// m68k_debug_uart_tx: CPU-writable 8N1 debug UART transmitter with TX FIFO.
// Ports:
//   clk, rst          clock, async active-high reset
//   sel, address      peripheral hit, byte offset (bit 0 ignored)
//   rd_ena, wr_ena    held bus requests
//   byte_ena, wr_data write lanes / data
//   rd_data, data_ack registered read data, one-cycle ack
//   uart_tx, tx_busy  serial line, activity flag
module m68k_debug_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic [3:0]  address,
   input  logic        rd_ena,
   input  logic        wr_ena,
   input  logic [1:0]  byte_ena,
   input  logic [15:0] wr_data,
   output logic [15:0] rd_data,
   output logic        data_ack,
   output logic        uart_tx,
   output logic        tx_busy
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // bus side
   logic          r_ack;
   logic          r_hold;
   logic          r_stat_rd;
   logic [15:0]   r_rd_data;
   logic          r_ovf;

   // fifo
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   // transmitter
   state_t        r_state;
   state_t        w_state_nxt;
   logic [BW-1:0] r_baud;
   logic [BW-1:0] w_baud_nxt;
   logic [2:0]    r_idx;
   logic [2:0]    w_idx_nxt;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          w_tx_nxt;
   logic          w_tick;

   logic          w_act;
   logic          w_req;
   logic          w_is_tx;
   logic          w_is_st;
   logic          w_push;
   logic [7:0]    w_push_byte;
   logic          w_full;
   logic          w_empty;
   logic          w_wr_ok;
   logic          w_ovf_set;
   logic          w_pop;
   logic          w_stat_req;
   logic [4:0]    w_cnt5;
   logic [15:0]   w_status;
   logic          w_unused_a0;

   assign w_unused_a0 = address[0];

   // r_hold blocks a held request from firing again after its ack
   assign w_act       = sel & (rd_ena | wr_ena);
   assign w_req       = w_act & ~r_ack & ~r_hold;
   assign w_is_tx     = (address[3:1] == 3'd0);
   assign w_is_st     = (address[3:1] == 3'd1);
   assign w_push      = w_req & wr_ena & w_is_tx & (|byte_ena);
   assign w_push_byte = byte_ena[0] ? wr_data[7:0] : wr_data[15:8];
   assign w_full      = (r_count == DEPTH_C);
   assign w_empty     = (r_count == '0);
   assign w_wr_ok     = w_push & ~w_full;
   assign w_ovf_set   = w_push & w_full;
   assign w_pop       = (r_state == S_IDLE) & ~w_empty;
   assign w_stat_req  = w_req & ~wr_ena & w_is_st;
   assign w_cnt5      = 5'(r_count);
   assign w_status    = {3'b000, w_cnt5, 4'b0000,
                         r_ovf, w_empty, w_full, tx_busy};

   assign tx_busy  = ~w_empty | (r_state != S_IDLE);
   assign uart_tx  = r_tx;
   assign data_ack = r_ack;
   assign rd_data  = r_rd_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack     <= 1'b0;
         r_hold    <= 1'b0;
         r_stat_rd <= 1'b0;
         r_rd_data <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_ack     <= w_req;
         r_hold    <= w_act & (r_hold | w_req);
         r_stat_rd <= w_stat_req;
         r_rd_data <= w_stat_req ? w_status : 16'h0000;
         // r_stat_rd is high exactly in the STATUS read ack cycle
         r_ovf     <= w_ovf_set | (r_ovf & ~r_stat_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_ok)
         r_mem[r_wptr] <= w_push_byte;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr_ok)
            r_wptr <= r_wptr + AW'(1);
         if (w_pop)
            r_rptr <= r_rptr + AW'(1);
         if (w_wr_ok & ~w_pop)
            r_count <= r_count + CW'(1);
         else if (w_pop & ~w_wr_ok)
            r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_idx   <= w_idx_nxt;
         r_tx    <= w_tx_nxt;
         if (w_pop)
            r_shift <= r_mem[r_rptr];
      end
   end

   assign w_tick = (r_baud == BAUD_LAST);

   // next line level is computed here so uart_tx comes straight from a flop
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud + BW'(1);
      w_idx_nxt   = r_idx;
      w_tx_nxt    = r_tx;
      unique case (r_state)
         S_IDLE: begin
            w_baud_nxt = '0;
            w_idx_nxt  = '0;
            w_tx_nxt   = 1'b1;
            if (!w_empty) begin
               w_state_nxt = S_START;
               w_tx_nxt    = 1'b0;
            end
         end
         S_START: begin
            if (w_tick) begin
               w_state_nxt = S_DATA;
               w_baud_nxt  = '0;
               w_tx_nxt    = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_tick) begin
               w_baud_nxt = '0;
               if (r_idx == 3'd7) begin
                  w_state_nxt = S_STOP;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
                  w_tx_nxt  = r_shift[r_idx + 3'd1];
               end
            end
         end
         S_STOP: begin
            if (w_tick) begin
               w_state_nxt = S_IDLE;
               w_baud_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_m68k_debug_uart_tx.sv
// tb_m68k_debug_uart_tx: scoreboard bench for the debug UART transmitter.
// Expected bytes are queued at each write and popped by the line monitor.
module tb_m68k_debug_uart_tx;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic [3:0]  address = '0;
   logic        rd_ena = 1'b0;
   logic        wr_ena = 1'b0;
   logic [1:0]  byte_ena = '0;
   logic [15:0] wr_data = '0;
   logic [15:0] rd_data;
   logic        data_ack;
   logic        uart_tx;
   logic        tx_busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [7:0] exp_q[$];
   int start_q[$];

   m68k_debug_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sel(sel),
      .address(address),
      .rd_ena(rd_ena),
      .wr_ena(wr_ena),
      .byte_ena(byte_ena),
      .wr_data(wr_data),
      .rd_data(rd_data),
      .data_ack(data_ack),
      .uart_tx(uart_tx),
      .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // line monitor: samples every cycle of a frame
   logic [9:0] m_bits;
   bit m_ok;
   bit m_abort;
   int m_st;
   initial forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
         m_st = cyc;
         m_ok = 1'b1;
         m_abort = 1'b0;
         m_bits = '0;
         for (int k = 0; k < 10*CPB; k++) begin
            if (k > 0) @(negedge clk);
            if (rst) m_abort = 1'b1;
            if (!m_abort) begin
               if (k % CPB == 0) m_bits[k/CPB] = uart_tx;
               else if (uart_tx !== m_bits[k/CPB]) m_ok = 1'b0;
            end
         end
         if (!m_abort) begin
            start_q.push_back(m_st);
            chk("frame_fmt", {m_ok, m_bits[0], m_bits[9]}, 3'b101);
            chk("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0)
               chk("rx_byte", m_bits[8:1], exp_q.pop_front());
         end
      end
   end

   task automatic bus(input logic wr, input logic [3:0] a,
                      input logic [1:0] be, input logic [15:0] d,
                      input bit push, output logic [15:0] rv);
      int n;
      @(negedge clk);
      sel = 1'b1;
      address = a;
      wr_ena = wr;
      rd_ena = ~wr;
      byte_ena = be;
      wr_data = d;
      if (push) exp_q.push_back(be[0] ? d[7:0] : d[15:8]);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (data_ack !== 1'b1 && n < 8);
      chk("ack_lat", n, 1);
      rv = rd_data;
      sel = 1'b0;
      wr_ena = 1'b0;
      rd_ena = 1'b0;
      byte_ena = '0;
   endtask

   task automatic wait_idle(input int lim);
      int n;
      n = 0;
      while ((tx_busy || exp_q.size() != 0) && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", n < lim, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] rv;
      int n;
      int acks;
      int si;
      int lows;

      repeat (3) @(negedge clk);
      chk("rst_tx", uart_tx, 1);
      chk("rst_ack", data_ack, 0);
      chk("rst_rd", rd_data, 0);
      chk("rst_busy", tx_busy, 0);
      rst = 1'b0;
      @(negedge clk);

      // register map
      bus(1'b0, 4'h2, 2'b11, 16'h0, 1'b0, rv);
      chk("status_idle", rv, 16'h0004);
      bus(1'b0, 4'h0, 2'b11, 16'h0, 1'b0, rv);
      chk("txdata_rd", rv, 16'h0000);
      bus(1'b0, 4'h6, 2'b11, 16'h0, 1'b0, rv);
      chk("rsvd_rd", rv, 16'h0000);
      bus(1'b1, 4'h2, 2'b11, 16'h00FF, 1'b0, rv);
      bus(1'b1, 4'hA, 2'b11, 16'h00EE, 1'b0, rv);
      bus(1'b0, 4'h3, 2'b11, 16'h0, 1'b0, rv);
      chk("status_a0", rv, 16'h0004);

      // single byte, low lane
      bus(1'b1, 4'h0, 2'b01, 16'h0041, 1'b1, rv);
      n = 0;
      while (uart_tx !== 1'b0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("start_lat", n, 1);
      n = 0;
      while (tx_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("busy_len", n, 40);
      wait_idle(200);

      // high lane, then no lanes
      bus(1'b1, 4'h0, 2'b10, 16'h5A00, 1'b1, rv);
      wait_idle(200);
      bus(1'b1, 4'h0, 2'b00, 16'h0077, 1'b0, rv);
      bus(1'b0, 4'h2, 2'b11, 16'h0, 1'b0, rv);
      chk("be00_status", rv, 16'h0004);
      wait_idle(200);

      // fill and overflow
      si = start_q.size();
      for (int i = 0; i < 10; i++)
         bus(1'b1, 4'h0, 2'b01, 16'(8'h30 + i), i < 9, rv);
      bus(1'b0, 4'h2, 2'b11, 16'h0, 1'b0, rv);
      chk("ovf_status", rv, 16'h080B);
      bus(1'b0, 4'h2, 2'b11, 16'h0, 1'b0, rv);
      chk("ovf_cleared", rv, 16'h0803);
      wait_idle(1000);
      chk("burst_frames", start_q.size() - si, 9);
      if (start_q.size() - si == 9)
         for (int j = 1; j < 9; j++)
            chk("frame_gap", start_q[si+j] - start_q[si+j-1], 41);

      // held request
      @(negedge clk);
      sel = 1'b1;
      address = 4'h0;
      wr_ena = 1'b1;
      byte_ena = 2'b01;
      wr_data = 16'h00C3;
      exp_q.push_back(8'hC3);
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (data_ack) acks++;
         if (i == 4) begin
            sel = 1'b0;
            wr_ena = 1'b0;
            byte_ena = '0;
         end
      end
      chk("held_acks", acks, 1);
      wait_idle(200);

      // reset mid-frame
      bus(1'b1, 4'h0, 2'b01, 16'h0055, 1'b1, rv);
      n = 0;
      while (uart_tx !== 1'b0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      repeat (17) @(negedge clk);
      chk("bit3_level", uart_tx, 0);
      rst = 1'b1;
      #1;
      chk("rst_mid_tx", uart_tx, 1);
      chk("rst_mid_busy", tx_busy, 0);
      chk("rst_mid_ack", data_ack, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus(1'b0, 4'h2, 2'b11, 16'h0, 1'b0, rv);
      chk("post_rst_status", rv, 16'h0004);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      chk("line_idle", lows, 0);

      chk("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/m68k_debug_uart_tx.md
M68K_DEBUG_UART_TX -- requirements
Module: m68k_debug_uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200 baud).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 8, TX FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sel  input  1  address decode hit for this peripheral from the SoC bus.
REQ-006 SHALL have port address  input  4  byte offset within peripheral; bit 0 ignored.
REQ-007 SHALL have port rd_ena  input  1  CPU read request, held until data_ack.
REQ-008 SHALL have port wr_ena  input  1  CPU write request, held until data_ack.
REQ-009 SHALL have port byte_ena  input  2  byte lanes; [1]=D15:8 (even address), [0]=D7:0 (odd address).
REQ-010 SHALL have port wr_data  input  16  CPU write data.
REQ-011 SHALL have port rd_data  output  16  register read data; valid while data_ack=1, else 0.
REQ-012 SHALL have port data_ack  output  1  one-cycle bus acknowledge.
REQ-013 SHALL have port uart_tx  output  1  serial output, 8N1, idle high.
REQ-014 SHALL have port tx_busy  output  1  high while the FIFO is non-empty or a frame is in flight.

Function
REQ-015 Register map: offset 0x0 TXDATA (write-only; reads return 0); offset 0x2 STATUS (read-only; writes acked, ignored); offsets 0x4-0xE read 0, writes ignored.
REQ-016 STATUS bits: [0] tx_busy, [1] fifo_full, [2] fifo_empty, [3] overflow (sticky), [8+:5] FIFO count, all other bits 0.
REQ-017 Request = sel & (rd_ena | wr_ena) & ~data_ack; data_ack SHALL be registered high exactly one cycle after the request cycle, then low for at least one cycle.
REQ-018 A request SHALL produce exactly one data_ack and at most one side effect, even when the request is held across several cycles.
REQ-019 A TXDATA write with byte_ena[0]=1 SHALL push wr_data[7:0]; with byte_ena=2'b10 it SHALL push wr_data[15:8]; with byte_ena=2'b00 it SHALL be acked with no push.
REQ-020 Push occurs in the request cycle; count updates on the next edge.
REQ-021 A push while count==FIFO_DEPTH SHALL be discarded and SHALL set overflow; it SHALL still be acked; fullness is judged on the pre-edge count, even if a pop occurs in the same cycle.
REQ-022 Overflow SHALL clear on the ack cycle of a STATUS read; if a new overflow occurs in that same cycle, overflow SHALL stay set.
REQ-023 Simultaneous push and pop with count<FIFO_DEPTH SHALL leave count unchanged and preserve FIFO order; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-025 IDLE: when the FIFO is non-empty, pop the head into the shift register and enter START on the next edge; uart_tx drops low in the first START cycle.
REQ-026 START SHALL hold uart_tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-027 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit index, then enter STOP.
REQ-028 STOP SHALL hold uart_tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-029 Back-to-back frames SHALL have exactly one IDLE cycle between the end of STOP and the next start bit, giving a frame period of 10*CLKS_PER_BIT+1 cycles.
REQ-030 The baud counter SHALL be sized ceil(log2(CLKS_PER_BIT)) bits and SHALL reload on every bit boundary.
REQ-031 uart_tx SHALL be driven from a flop, so no combinational glitches appear on the pin.

Reset
REQ-032 While rst=1, the block SHALL hold: uart_tx=1, data_ack=0, rd_data=0, tx_busy=0, FSM=IDLE, FIFO empty, overflow=0, all counters 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately; after rst falls, no partial or stale byte is transmitted.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-034 Write TXDATA 0x0041 with byte_ena=2'b01 -> data_ack one cycle later; uart_tx=0 for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then 1 for 4 cycles; tx_busy low afterwards.
REQ-035 Write byte_ena=2'b10 with data 0x5A00 -> byte 0x5A transmitted; byte_ena=2'b00 -> acked, STATUS count stays 0.
REQ-036 Ten writes 0x30..0x39 back-to-back while the first frame is in flight -> STATUS shows fifo_full=1 and overflow=1; the wire carries 0x30..0x38 with 41-cycle frame spacing; 0x39 is lost; the next STATUS read returns overflow=1 and a following read returns overflow=0.
REQ-037 Write held across 5 cycles with rd_ena/wr_ena high -> exactly one data_ack pulse and one byte pushed.
REQ-038 Assert rst during data bit 3 of 0x55 -> uart_tx=1 within the same cycle, STATUS=0x0004 after release, and the line stays idle.
